int_enc148: RTL and testbench
=============================

# int_enc148

Registered 8-line interrupt priority encoder using 74x148 pin conventions: active-low request lines `I[7:0]`, active-low code `A_L[2:0]`, and `GS_L`/`EO_L` status.
- Sits on the request side of the existing 3-to-8 decoder logic: the decoder fans a code out to eight lines, and this block collapses eight request lines back into one code.
- Each request assertion is captured as a pending bit.
- The highest pending index is presented with a VALID/ACK handshake; ACK retires that request.

## Interface
- No parameters; width is fixed at 8 requests / 3-bit code.
- `CLK` input 1: single clock; all state updates on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `EI_L` input 1: enable, active low; when high, new request edges are not captured.
- `I` input 8: request lines, active low (`I[7]` highest priority).
- `ACK` input 1: consumer acknowledges the presented code.
- `A_L` output 3: encoded index, active low, registered.
- `GS_L` output 1: group select, active low; always equals `~VALID`.
- `EO_L` output 1: enable out, active low, registered; 0 when enabled and nothing is pending or presented.
- `VALID` output 1: code on `A_L` is valid, registered.

## Operation
- **Input stage.**
  - `cur` = synchronized `I` (see Configuration).
  - `prev` register resets to 8'hFF.
  - `rise = prev & ~cur`, i.e. a 1→0 transition on a request line.
  - Edge-triggered: a line held low produces exactly one request.
- **Pending register.** `pending[7:0]`, reset 0. Each cycle:
  - `pending <= (pending & ~clr) | (rise & {8{~EI_L}})`.
  - `clr` is one-hot at the retired index on an ACK cycle, else 0.
  - Set wins over clear on the same bit in the same cycle (request re-pended).
- **FSM states: IDLE, PRESENT.**
  - IDLE: if `EI_L==0` and `pending!=0`, register `A_L <= ~idx`, where `idx` is the highest set bit of `pending`. Then `VALID<=1`, go to PRESENT. Otherwise stay.
  - PRESENT: `A_L` and `VALID` hold. On `ACK==1`: clear `pending[idx]`, `VALID<=0`, `A_L<=3'b111`, go to IDLE.
  - ACK in IDLE is ignored.
  - A higher-priority request arriving during PRESENT does not preempt; it is presented after the current ACK.
  - `EI_L` rising during PRESENT does not withdraw the presented code; IDLE does not start a new presentation while `EI_L==1`.
- **EO_L.** Registered: `EO_L <= ~(~EI_L && pending_next==0 && state_next==IDLE)`.
- **Reset values** (any cycle, including mid-presentation): state IDLE, `pending` 0, `prev`/sync flops 8'hFF, `A_L` 3'b111, `VALID` 0, `GS_L` 1, `EO_L` 1.

## Timing
- Let request line `n` fall before rising edge k.
- With `INT_ENC148_SYNC_EN`:
  - Synchronizer stages load at edges k and k+1.
  - `pending[n]` is set at k+2.
  - `VALID`/`A_L` are valid after k+3.
- Without `INT_ENC148_SYNC_EN`: `pending[n]` is set at k; `VALID` is valid after k+1.
- `ACK` is sampled at the edge where `VALID==1`. `VALID` drops after that same edge.
- Back-to-back presentation: the next code appears at the earliest one edge later, because a mandatory IDLE cycle separates presentations.
- Maximum throughput is one request per 2 cycles.
- Sustained `ACK=1` is legal and retires each presentation on its first valid cycle.

## Configuration
- `INT_ENC148_SYNC_EN` defined:
  - Two-flop synchronizer on all 8 `I` lines, both flops reset to 1; `cur` = second flop.
  - Use when requests come from switches or another clock domain.
- `INT_ENC148_SYNC_EN` undefined:
  - `cur = I` directly; `I` must be synchronous to `CLK`.
  - Latency reduced by 2 cycles.
- No other behaviour changes.

## Structure
- Shared package `int_enc148_pkg`:
  - State enum (`IDLE`, `PRESENT`).
  - Constants `NREQ=8`, `CODE_W=3`, `REQ_IDLE=8'hFF`.
  - Function `prio_idx(logic [7:0]) -> logic [2:0]`, returning the highest set bit.
- One natural sub-module: `int_enc148_sync`, the 8-bit two-flop synchronizer. It is instantiated only under the macro.
- Edge detection, pending register, FSM and output registers stay in the top.

## Test plan
- **Reset check.** Assert `RST` for 2 cycles with `I=8'h00` → `A_L=3'b111`, `VALID=0`, `GS_L=1`, `EO_L=1`. After release with `I=8'hFF`, `EI_L=0` → `EO_L=0`, `pending=0`.
- **Single request.** Drop `I[5]` only, `ACK=0` → after 4 edges (2 without the macro): `VALID=1`, `A_L=3'b010`, `GS_L=0`, `EO_L=1`; hold 10 cycles stable. `ACK=1` for one cycle → `VALID=0`, `A_L=3'b111`. Keep `I[5]` low → no re-request.
- **Priority order.** Drop `I[1]`, `I[6]`, `I[3]` on the same edge, `ACK=1` constant → presented codes, as index and `A_L`:
  - 6 (`A_L=3'b001`)
  - 3 (`A_L=3'b100`)
  - 1 (`A_L=3'b110`)
  - each with one IDLE cycle between; then `EO_L=0`.
- **No preemption and set-wins-clear.** While presenting idx 2, drop `I[7]` → `A_L` stays 3'b101 until ACK; next presentation is 7. Also: ACK idx 4 on the same edge that a new `I[4]` fall reaches `rise` → `pending[4]` remains 1 and 4 is re-presented.
- **Enable gating.** With `EI_L=1`, toggle `I[0]` low → nothing captured, `EO_L=1`, `VALID=0`. Set `EI_L=0` → still nothing until a fresh falling edge.
- **Reset mid-operation.** `RST` during PRESENT with 3 pending → next cycle all outputs at reset values and `pending=0`. No stale code is presented after release.

Source files
------------

// File: rtl/int_enc148_pkg.sv
// int_enc148_pkg: shared state enum, widths and priority helper for the 8-line interrupt encoder
package int_enc148_pkg;
  typedef enum logic {IDLE, PRESENT} state_e;
  localparam int NREQ = 8;
  localparam int CODE_W = 3;
  localparam logic [NREQ-1:0] REQ_IDLE = 8'hFF;
  function automatic logic [CODE_W-1:0] prio_idx(input logic [NREQ-1:0] v);
    prio_idx = '0;
    for (int i = 0; i < NREQ; i++) if (v[i]) prio_idx = CODE_W'(i);
  endfunction
endpackage

// File: rtl/int_enc148_if.sv
// int_enc148_if: request/code handshake bundle between requesters (master) and the encoder (slave)
interface int_enc148_if;
  import int_enc148_pkg::*;
  logic EI_L;
  logic [NREQ-1:0] I;
  logic ACK;
  logic [CODE_W-1:0] A_L;
  logic GS_L;
  logic EO_L;
  logic VALID;
  modport master (output EI_L, I, ACK, input A_L, GS_L, EO_L, VALID);
  modport slave (input EI_L, I, ACK, output A_L, GS_L, EO_L, VALID);
endinterface

// File: rtl/int_enc148_sync.sv
// int_enc148_sync: two-flop synchronizer for the active-low request lines, both stages reset to idle-high
module int_enc148_sync
  import int_enc148_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] d,
  output logic [NREQ-1:0] q
);
  logic [NREQ-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= REQ_IDLE;
      s2_q <= REQ_IDLE;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/int_enc148.sv
// int_enc148: registered 74x148-style priority encoder with edge-captured pending requests and VALID/ACK
// Define INT_ENC148_SYNC_EN to insert a two-flop synchronizer on I (adds 2 cycles of latency).
module int_enc148
  import int_enc148_pkg::*;
(
  input logic         CLK,
  input logic         RST,
  int_enc148_if.slave bus
);
  state_e state_q, state_d;
  logic [NREQ-1:0] cur, prev_q, prev_d, pending_q, pending_d, rise, clr;
  logic [CODE_W-1:0] a_l_q, a_l_d;
  logic valid_q, valid_d, eo_l_q, eo_l_d, go, retire;
`ifdef INT_ENC148_SYNC_EN
  int_enc148_sync u_sync (.clk(CLK), .rst(RST), .d(bus.I), .q(cur));
`else
  assign cur = bus.I;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      prev_q    <= REQ_IDLE;
      pending_q <= '0;
      a_l_q     <= '1;
      valid_q   <= 1'b0;
      eo_l_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      a_l_q     <= a_l_d;
      valid_q   <= valid_d;
      eo_l_q    <= eo_l_d;
    end
  end
  // the presented index is recovered from A_L, so no separate index register is kept
  always_comb begin
    prev_d    = cur;
    rise      = prev_q & ~cur;
    retire    = state_q == PRESENT && bus.ACK;
    clr       = retire ? NREQ'(1) << ~a_l_q : '0;
    pending_d = (pending_q & ~clr) | (rise & {NREQ{~bus.EI_L}});
    go        = state_q == IDLE && !bus.EI_L && |pending_q;
    state_d   = go ? PRESENT : retire ? IDLE : state_q;
  end
  always_comb begin
    a_l_d   = go ? ~prio_idx(pending_q) : retire ? '1 : a_l_q;
    valid_d = state_d == PRESENT;
    eo_l_d  = ~(~bus.EI_L && pending_d == '0 && state_d == IDLE);
  end
  assign bus.A_L   = a_l_q;
  assign bus.GS_L  = ~valid_q;
  assign bus.EO_L  = eo_l_q;
  assign bus.VALID = valid_q;
endmodule

// File: tb/tb_int_enc148.sv
// tb_int_enc148: randomized and directed scoreboard bench for int_enc148 against a request-set reference model
module tb_int_enc148;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int_enc148_if bus ();
  int_enc148 dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int pres_log[$];
  int n_pres = 0;

  logic [7:0] m_s1 = 8'hFF, m_s2 = 8'hFF, m_prev = 8'hFF;
  bit   m_pend[8];
  bit   m_busy = 1'b0;
  int   m_idx = 0;
  bit   m_eo = 1'b1;
  bit   last_v = 1'b0;

`ifdef INT_ENC148_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.VALID && n < 12) begin
      tick();
      n++;
    end
    chk("wait_valid", int'(bus.VALID), 1);
  endtask

  task automatic settle();
    bus.I = 8'hFF;
    bus.EI_L = 1'b0;
    bus.ACK = 1'b1;
    tick(24);
    bus.ACK = 1'b0;
    tick();
  endtask

  // Reference: a set of outstanding requests; one is granted at a time, highest number first,
  // and a grant may only begin when nothing is currently being presented.
  always @(posedge clk) begin
    logic [7:0] cur;
    bit any;
    int hi;
    if (rst) begin
      m_s1 = 8'hFF; m_s2 = 8'hFF; m_prev = 8'hFF;
      foreach (m_pend[n]) m_pend[n] = 1'b0;
      m_busy = 1'b0; m_idx = 0; m_eo = 1'b1;
      exp_q.delete();
    end else begin
`ifdef INT_ENC148_SYNC_EN
      cur = m_s2;
`else
      cur = bus.I;
`endif
      any = 1'b0;
      hi = 0;
      foreach (m_pend[n]) if (m_pend[n]) begin any = 1'b1; hi = n; end
      if (!m_busy && !bus.EI_L && any) begin
        m_busy = 1'b1;
        m_idx = hi;
        exp_q.push_back(hi);
      end else if (m_busy && bus.ACK) begin
        m_busy = 1'b0;
        m_pend[m_idx] = 1'b0;
      end
      for (int n = 0; n < 8; n++)
        if (m_prev[n] == 1'b1 && cur[n] == 1'b0 && !bus.EI_L) m_pend[n] = 1'b1;
      any = 1'b0;
      foreach (m_pend[n]) if (m_pend[n]) any = 1'b1;
      m_eo = !(!bus.EI_L && !any && !m_busy);
      m_prev = cur;
      m_s2 = m_s1;
      m_s1 = bus.I;
    end
  end

  always @(negedge clk) begin
    logic [2:0] code;
    code = ~bus.A_L;
    chk("valid", int'(bus.VALID), int'(m_busy));
    chk("gs_l", int'(bus.GS_L), int'(!m_busy));
    chk("eo_l", int'(bus.EO_L), int'(m_eo));
    if (bus.VALID && !last_v) begin
      if (exp_q.size() == 0) chk("unexpected_present", int'(code), -1);
      else chk("code", int'(code), exp_q.pop_front());
      pres_log.push_back(int'(code));
      n_pres++;
    end else if (m_busy) chk("a_l_hold", int'(code), m_idx);
    else chk("a_l_idle", int'(bus.A_L), 7);
    last_v = bus.VALID;
  end

  initial begin
    bus.I = 8'h00;
    bus.EI_L = 1'b0;
    bus.ACK = 1'b0;
    rst = 1'b1;
    tick(2);
    chk("rst_a_l", int'(bus.A_L), 7);
    chk("rst_valid", int'(bus.VALID), 0);
    chk("rst_gs_l", int'(bus.GS_L), 1);
    chk("rst_eo_l", int'(bus.EO_L), 1);
    rst = 1'b0;
    bus.I = 8'hFF;
    tick();
    chk("idle_eo_l", int'(bus.EO_L), 0);

    // single request on line 5 with exact latency
    bus.I = 8'hDF;
    tick(LAT - 1);
    chk("single_early", int'(bus.VALID), 0);
    tick();
    chk("single_valid", int'(bus.VALID), 1);
    chk("single_a_l", int'(bus.A_L), 3'b010);
    chk("single_gs_l", int'(bus.GS_L), 0);
    chk("single_eo_l", int'(bus.EO_L), 1);
    tick(10);
    chk("single_hold", int'(bus.A_L), 3'b010);
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
    chk("single_ack_valid", int'(bus.VALID), 0);
    chk("single_ack_a_l", int'(bus.A_L), 7);
    tick(8);
    chk("single_no_rereq", int'(bus.VALID), 0);
    settle();

    // priority order with ACK held high
    pres_log.delete();
    bus.ACK = 1'b1;
    bus.I = 8'hB5;
    tick(LAT + 8);
    chk("prio_count", pres_log.size(), 3);
    if (pres_log.size() == 3) begin
      chk("prio_0", pres_log[0], 6);
      chk("prio_1", pres_log[1], 3);
      chk("prio_2", pres_log[2], 1);
    end
    chk("prio_eo_l", int'(bus.EO_L), 0);
    settle();

    // no preemption by a higher request
    bus.I = 8'hFB;
    wait_valid();
    bus.I = 8'h7B;
    tick(6);
    chk("nopre_hold", int'(bus.A_L), 3'b101);
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
    wait_valid();
    chk("nopre_next", int'(bus.A_L), 3'b000);
    settle();

    // retire 4 on the same edge its fresh fall reaches the edge detector
    bus.I = 8'hEF;
    wait_valid();
    bus.I = 8'hFF;
    tick(4);
    bus.I = 8'hEF;
`ifdef INT_ENC148_SYNC_EN
    tick(2);
`endif
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
    chk("swc_drop", int'(bus.VALID), 0);
    wait_valid();
    chk("swc_repres", int'(bus.A_L), 3'b011);
    settle();

    // enable gating
    bus.EI_L = 1'b1;
    bus.I = 8'hFE;
    tick(6);
    chk("gate_valid", int'(bus.VALID), 0);
    chk("gate_eo_l", int'(bus.EO_L), 1);
    bus.EI_L = 1'b0;
    tick(6);
    chk("gate_no_late", int'(bus.VALID), 0);
    bus.I = 8'hFF;
    tick(3);
    bus.I = 8'hFE;
    wait_valid();
    chk("gate_fresh", int'(bus.A_L), 3'b111);
    settle();

    // reset while presenting with more pending
    bus.I = 8'hB5;
    wait_valid();
    rst = 1'b1;
    bus.I = 8'hFF;
    tick();
    chk("mid_rst_valid", int'(bus.VALID), 0);
    chk("mid_rst_a_l", int'(bus.A_L), 7);
    chk("mid_rst_gs_l", int'(bus.GS_L), 1);
    chk("mid_rst_eo_l", int'(bus.EO_L), 1);
    rst = 1'b0;
    tick(8);
    chk("mid_rst_stale", int'(bus.VALID), 0);

    // random traffic against the reference model
    begin
      int start = n_pres;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 3) == 0) bus.I[$urandom_range(0, 7)] ^= 1'b1;
        bus.EI_L = ($urandom_range(0, 9) == 0);
        bus.ACK = $urandom_range(0, 1);
        tick();
      end
      settle();
      chk("rand_activity", int'(n_pres - start >= 10), 1);
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
